// File: rtl/adder_pkg.sv
// adder_pkg: shared default operand width for the adder family
package adder_pkg;
    localparam int ADDER_N = 16;
endpackage

// File: rtl/dff_reg.sv
// dff_reg: W-bit register with sync active-low clear; ports clk, rst_n, d -> q
module dff_reg #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_d, q_q;
    always_comb q_d = rst_n ? d : '0;
    always_ff @(posedge clk) q_q <= q_d;
    assign q = q_q;
endmodule

// File: rtl/full_adder.sv
// full_adder: 1-bit full adder; ports a, b, cin -> s (sum), cout (carry), p (propagate)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout,
    output logic p
);
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (p & cin);
endmodule

// File: rtl/rca_reg_adder.sv
// rca_reg_adder: N-bit ripple-carry adder; A, B, Cin -> comb S, Cout, P; registered out = {Cout, S}
module rca_reg_adder
    import adder_pkg::*;
#(
    parameter int N = ADDER_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic [N-1:0] P,
    output logic [N:0]   out
);
    logic [N:0] c;
    assign c[0] = Cin;
    for (genvar i = 0; i < N; i++) begin : g_fa
        full_adder u_fa (
            .a   (A[i]),
            .b   (B[i]),
            .cin (c[i]),
            .s   (S[i]),
            .cout(c[i+1]),
            .p   (P[i])
        );
    end
    assign Cout = c[N];
    dff_reg #(.W(N + 1)) u_out (
        .clk  (clk),
        .rst_n(rst_n),
        .d    ({Cout, S}),
        .q    (out)
    );
endmodule

// File: tb/tb_rca_reg_adder.sv
// tb_rca_reg_adder: scoreboard bench for rca_reg_adder against an arithmetic model
module tb_rca_reg_adder;
    localparam int N = 16;
    logic         clk = 0;
    logic         rst_n = 0;
    logic [N-1:0] A = '0, B = '0, S, P;
    logic         Cin = 0, Cout;
    logic [N:0]   out;
    int           tests = 0, fails = 0;
    logic [N:0]   q[$];
    rca_reg_adder #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Cin(Cin),
        .S(S), .Cout(Cout), .P(P), .out(out)
    );
    always #5 clk = ~clk;
    task automatic apply(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci, input logic r);
        logic [N:0] e;
        @(negedge clk);
        A = a; B = b; Cin = ci; rst_n = r;
        #1;
        e = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
        tests++;
        if ({Cout, S} !== e) begin
            fails++;
            $display("FAIL sum a=%h b=%h cin=%0d got=%h want=%h", a, b, ci, {Cout, S}, e);
        end
        tests++;
        if (P !== (a ^ b)) begin
            fails++;
            $display("FAIL prop a=%h b=%h got=%h want=%h", a, b, P, a ^ b);
        end
        q.push_back(r ? e : '0);
    endtask
    initial begin
        logic [N:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (out !== e) begin
                    fails++;
                    $display("FAIL out t=%0t got=%h want=%h", $time, out, e);
                end
            end
        end
    end
    initial begin
        int unsigned s;
        s = $urandom(42);
        apply(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        apply(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        apply(16'hFFFF, 16'h0000, 1'b1, 1'b1);
        apply(16'hFFFF, 16'h0000, 1'b1, 1'b1);
        apply(16'h1234, 16'h4321, 1'b0, 1'b1);
        apply(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        apply(16'h0000, 16'h0000, 1'b0, 1'b1);
        apply(16'h0000, 16'h0000, 1'b1, 1'b1);
        apply(16'h1234, 16'h4321, 1'b0, 1'b1);
        apply(16'h1234, 16'h4321, 1'b0, 1'b0);
        apply(16'h1234, 16'h4321, 1'b0, 1'b1);
        apply(16'h8000, 16'h8000, 1'b0, 1'b1);
        for (int k = 0; k < 10000; k++)
            apply(N'($urandom), N'($urandom), 1'($urandom), 1'b1);
        @(posedge clk);
        #3;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end
endmodule
